// File: rtl/datapath_if.sv
// Control/status bundle between a controller (master) and the datapath (slave).
// No handshake: the master presents a full control word every cycle and the slave's outputs follow it.
interface datapath_if #(
   parameter int WIDTH    = 16,
   parameter int D_ADDR_W = 8,
   parameter int R_ADDR_W = 4
);
   logic                D_wr;
   logic                RF_s;
   logic                RF_W_en;
   logic [D_ADDR_W-1:0] D_addr;
   logic [R_ADDR_W-1:0] RF_W_addr;
   logic [R_ADDR_W-1:0] RF_A_addr;
   logic [R_ADDR_W-1:0] RF_B_addr;
   logic [3:0]          ALU_sel;
   logic [WIDTH-1:0]    ALU_A_Out;
   logic [WIDTH-1:0]    ALU_B_Out;
   logic [WIDTH-1:0]    ALU_Out;
   logic [2:0]          Flags_Out;

   modport master (
      output D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel,
      input  ALU_A_Out, ALU_B_Out, ALU_Out, Flags_Out
   );

   modport slave (
      input  D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel,
      output ALU_A_Out, ALU_B_Out, ALU_Out, Flags_Out
   );
endinterface

// File: rtl/datapath.sv
// Register file + ALU + data memory datapath with registered {C,N,Z} flags.
// Memory reads land in a D_rdata register one cycle after the address is presented.
module datapath #(
   parameter int WIDTH    = 16,
   parameter int D_ADDR_W = 8,
   parameter int R_ADDR_W = 4
) (
   input logic       clk,
   input logic       reset,
   datapath_if.slave bus
);
   localparam int NREG = 1 << R_ADDR_W;
   localparam int NMEM = 1 << D_ADDR_W;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] rf_q [NREG];
   logic [WIDTH-1:0] mem_q [NMEM];
   logic [WIDTH-1:0] d_rdata_q;
   logic [2:0]       flags_q;

   logic [WIDTH-1:0] a_w, b_w;
   logic [WIDTH-1:0] result_w;
   logic             carry_w;
   logic [WIDTH:0]   wide_w;
   logic [WIDTH-1:0] rf_wdata_d;
   logic [2:0]       flags_d;

   assign a_w = rf_q[bus.RF_A_addr];
   assign b_w = rf_q[bus.RF_B_addr];

   always_comb begin
      result_w = '0;
      carry_w  = 1'b0;
      wide_w   = '0;
      case (bus.ALU_sel)
         4'd0: begin
            wide_w   = {1'b0, a_w} + {1'b0, b_w};
            result_w = wide_w[WIDTH-1:0];
            carry_w  = wide_w[WIDTH];
         end
         4'd1: begin
            result_w = a_w - b_w;
            carry_w  = (a_w < b_w);
         end
         4'd2: result_w = a_w & b_w;
         4'd3: result_w = a_w | b_w;
         4'd4: result_w = a_w ^ b_w;
         4'd5: result_w = ~a_w;
         4'd6: begin
            result_w = {a_w[WIDTH-2:0], 1'b0};
            carry_w  = a_w[WIDTH-1];
         end
         4'd7: begin
            result_w = {1'b0, a_w[WIDTH-1:1]};
            carry_w  = a_w[0];
         end
         4'd8: begin
            wide_w   = {1'b0, a_w} + {1'b0, ONE};
            result_w = wide_w[WIDTH-1:0];
            carry_w  = wide_w[WIDTH];
         end
         4'd9: begin
            result_w = a_w - ONE;
            carry_w  = (a_w == '0);
         end
         4'd10:   result_w = a_w;
         4'd11:   result_w = b_w;
         default: result_w = '0;
      endcase
   end

   assign flags_d    = {carry_w, result_w[WIDTH-1], (result_w == '0)};
   assign rf_wdata_d = bus.RF_s ? d_rdata_q : result_w;

   // Register file, read-data register and flags; the register file has no write-to-read bypass.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         d_rdata_q <= '0;
         flags_q   <= '0;
      end else begin
         d_rdata_q <= mem_q[bus.D_addr];
         if (bus.RF_W_en) rf_q[bus.RF_W_addr] <= rf_wdata_d;
         if (bus.RF_W_en && !bus.RF_s) flags_q <= flags_d;
      end
   end

   // Memory contents survive reset; only the write is blocked while reset is high.
   always_ff @(posedge clk) begin
      if (!reset && bus.D_wr) mem_q[bus.D_addr] <= a_w;
   end

   assign bus.ALU_A_Out = a_w;
   assign bus.ALU_B_Out = b_w;
   assign bus.ALU_Out   = result_w;
   assign bus.Flags_Out = flags_q;
endmodule
